// File: rtl/tpu_row_feed_sequencer.sv
// rtl/tpu_row_feed_sequencer.sv - job sequencer gating a valid source into a fixed-latency datapath
module tpu_row_feed_sequencer #(
  parameter int LATENCY   = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 abort,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic                 dp_load,
  output logic                 dp_first,
  output logic                 dp_last,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LATENCY-1:0]   r_sh_valid;
  logic [LATENCY-1:0]   r_sh_last;

  logic w_feed;
  logic w_active_abort;
  logic w_load;
  logic w_first;
  logic w_last;

  assign w_feed         = (r_state == S_FEED);
  assign w_active_abort = abort & ((r_state == S_FEED) | (r_state == S_DRAIN));
  // An abort in the same cycle as a beat cancels that beat entirely.
  assign w_load         = w_feed & src_valid & ~abort;
  assign w_first        = w_load & (r_cnt == '0);
  assign w_last         = w_load & (r_cnt == (r_len - LEN_WIDTH'(1)));

  assign src_ready = w_feed;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign dp_load   = w_load;
  assign dp_first  = w_first;
  assign dp_last   = w_last;
  assign out_valid = r_sh_valid[LATENCY-1];
  assign out_last  = r_sh_last[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (len != '0) begin
              r_len   <= len;
              r_state <= S_FEED;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_FEED: begin
          if (abort) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_load) begin
            r_cnt <= r_cnt + LEN_WIDTH'(1);
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (out_last) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shadow of the datapath: one {valid,last} pair per pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_valid <= '0;
      r_sh_last  <= '0;
    end else if (w_active_abort) begin
      r_sh_valid <= '0;
      r_sh_last  <= '0;
    end else begin
      r_sh_valid[0] <= w_load;
      r_sh_last[0]  <= w_last;
      for (int i = 1; i < LATENCY; i++) begin
        r_sh_valid[i] <= r_sh_valid[i-1];
        r_sh_last[i]  <= r_sh_last[i-1];
      end
    end
  end

endmodule

// File: tb/tb_tpu_row_feed_sequencer.sv
// tb/tb_tpu_row_feed_sequencer.sv - self-checking bench for tpu_row_feed_sequencer
module tb_tpu_row_feed_sequencer;

  localparam int L    = 8;
  localparam int LW   = 8;
  localparam int MAXC = 320;

  localparam int B_RDY = 7;
  localparam int B_LD  = 6;
  localparam int B_FST = 5;
  localparam int B_LST = 4;
  localparam int B_OV  = 3;
  localparam int B_OL  = 2;
  localparam int B_BSY = 1;
  localparam int B_DN  = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          abort;
  logic          src_valid;
  logic          src_ready, dp_load, dp_first, dp_last;
  logic          out_valid, out_last, busy, done;

  tpu_row_feed_sequencer #(.LATENCY(L), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .dp_load   (dp_load),
    .dp_first  (dp_first),
    .dp_last   (dp_last),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ln;
    logic [31:0] vpat;
    int          ab;
    int          noise;
    int          exp_done;
    int          exp_nloads;
    int          exp_ol;
  } vec_t;

  bit       vin   [MAXC];
  bit [7:0] exp_o [MAXC];
  int       n_cyc;
  int       errors = 0;
  int       checks = 0;

  function automatic bit [7:0] outs();
    return {src_ready, dp_load, dp_first, dp_last, out_valid, out_last, busy, done};
  endfunction

  // Event-level reference: beats land in FEED cycles with src_valid, results
  // appear L cycles later, done one cycle after the last result, and an abort
  // in FEED/DRAIN truncates everything after it.
  task automatic build_model(input int ln, input int ab);
    int cnt, lastload, done_c;
    for (int k = 0; k < MAXC; k++) exp_o[k] = '0;
    cnt = 0;
    lastload = 0;
    if (ln == 0) begin
      done_c = 1;
    end else begin
      for (int k = 1; (cnt < ln) && (k < MAXC - L - 2); k++) begin
        exp_o[k][B_RDY] = 1'b1;
        if (vin[k]) begin
          exp_o[k][B_LD]   = 1'b1;
          exp_o[k][B_FST]  = (cnt == 0);
          exp_o[k][B_LST]  = (cnt == ln - 1);
          exp_o[k+L][B_OV] = 1'b1;
          exp_o[k+L][B_OL] = (cnt == ln - 1);
          cnt++;
          lastload = k;
        end
      end
      done_c = lastload + L + 1;
    end
    for (int k = 1; k <= done_c; k++) exp_o[k][B_BSY] = 1'b1;
    exp_o[done_c][B_DN] = 1'b1;
    n_cyc = done_c + 1;
    if (ab >= 1 && ab < done_c) begin
      exp_o[ab][B_LD]  = 1'b0;
      exp_o[ab][B_FST] = 1'b0;
      exp_o[ab][B_LST] = 1'b0;
      for (int k = ab + 1; k < MAXC; k++) exp_o[k] = '0;
      n_cyc = ab + 1;
    end
  endtask

  task automatic run_job(input int ln, input int ab, input int noise,
                         output int o_done, output int o_nloads, output int o_ol);
    bit [7:0] got;
    build_model(ln, ab);
    o_done = -1;
    o_nloads = 0;
    o_ol = -1;
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk);
      #1;
      src_valid = vin[k];
      abort     = (k == ab);
      if (k == 0) begin
        start = 1'b1;
        len   = LW'(ln);
      end else if (noise == 1) begin
        start = 1'($urandom_range(0, 1));
        len   = LW'($urandom);
      end else if (noise == 2) begin
        start = 1'b1;
        len   = ~LW'(ln);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      got = outs();
      checks++;
      if (got !== exp_o[k]) begin
        errors++;
        $display("FAIL cycle_%0d (len=%0d ab=%0d): got %b expected %b [rdy ld fst lst ov ol bsy dn]",
                 k, ln, ab, got, exp_o[k]);
      end
      if (dp_load) o_nloads++;
      if (done && o_done < 0) o_done = k;
      if (out_last && o_ol < 0) o_ol = k;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    src_valid = 1'b0;
  endtask

  task automatic fill_vin(input logic [31:0] pat);
    for (int k = 0; k < MAXC; k++) vin[k] = (k < 32) ? pat[k] : 1'b1;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  vec_t tbl [9];
  int   od, onl, ool;

  initial begin
    tbl[0] = '{4,   32'hFFFF_FFFF, -1, 0, 13, 4, 12};
    tbl[1] = '{3,   32'h0000_0032, -1, 0, 14, 3, 13};
    tbl[2] = '{0,   32'hFFFF_FFFF, -1, 0, 1,  0, -1};
    tbl[3] = '{2,   32'hFFFF_FFFF, 5,  0, -1, 2, -1};
    tbl[4] = '{1,   32'hFFFF_FFFF, -1, 0, 10, 1, 9};
    tbl[5] = '{2,   32'hFFFF_FFFF, 1,  0, -1, 0, -1};
    tbl[6] = '{3,   32'hFFFF_FFFF, 0,  0, 12, 3, 11};
    tbl[7] = '{2,   32'hFFFF_FFFF, 11, 0, 11, 2, 10};
    tbl[8] = '{3,   32'hFFFF_FFFF, -1, 2, 12, 3, 11};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src_valid = 1'b1;
    len = '0;
    #12;
    check_int("reset_outputs", int'(outs()), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_valid = 1'b0;

    for (int i = 0; i < 9; i++) begin
      fill_vin(tbl[i].vpat);
      run_job(tbl[i].ln, tbl[i].ab, tbl[i].noise, od, onl, ool);
      check_int($sformatf("vec%0d_done_cycle", i), od, tbl[i].exp_done);
      check_int($sformatf("vec%0d_loads", i), onl, tbl[i].exp_nloads);
      check_int($sformatf("vec%0d_out_last_cycle", i), ool, tbl[i].exp_ol);
    end

    fill_vin(32'hFFFF_FFFF);
    run_job(255, -1, 1, od, onl, ool);
    check_int("maxlen_done_cycle", od, 255 + L + 1);
    check_int("maxlen_loads", onl, 255);

    // Reset asserted mid-FEED with a beat being offered.
    @(posedge clk);
    #1;
    start = 1'b1;
    len = LW'(5);
    src_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("reset_midjob_outputs", int'(outs()), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_valid = 1'b0;
    fill_vin(32'hFFFF_FFFF);
    run_job(2, -1, 0, od, onl, ool);
    check_int("post_reset_done_cycle", od, 2 + L + 1);

    for (int j = 0; j < 25; j++) begin
      int thr, ln, ab;
      thr = $urandom_range(1, 4);
      for (int k = 0; k < MAXC; k++)
        vin[k] = (k > 200) ? 1'b1 : ($urandom_range(0, 3) < thr);
      ln = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
      run_job(ln, ab, 1, od, onl, ool);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_row_feed_sequencer.md
# tpu_row_feed_sequencer

Sequences one job of operand beats into a fixed-latency, free-running TPU datapath, such as a register delay line or a pipelined RNS MAC row. It accepts a start command with a beat count and gates a valid/ready source into the datapath. A shadow valid pipeline tracks the in-flight beats so that output-valid flags line up with datapath results. After the last result emerges, it pulses done.

## Interface
Parameters:
- LATENCY, 8, pipeline depth of the controlled datapath in clock cycles (≥1); out_valid trails dp_load by exactly LATENCY cycles.
- LEN_WIDTH, 8, width of the job length field and beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_WIDTH  beat count for the job; latched when start is accepted.
- abort  in  1  synchronous job cancel.
- src_valid  in  1  source beat available.
- src_ready  out  1  sequencer accepts a beat.
- dp_load  out  1  qualifies the beat entering the datapath this cycle (src_valid & src_ready).
- dp_first  out  1  with dp_load, marks beat 0 of the job.
- dp_last  out  1  with dp_load, marks beat len-1 of the job.
- out_valid  out  1  datapath output holds a job result this cycle.
- out_last  out  1  with out_valid, marks the final result.
- busy  out  1  job in progress (state ≠ IDLE).
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE**
  - busy=0, src_ready=0.
  - start with len≠0: latch len, clear the beat counter, go to FEED.
  - start with len=0: go to DONE directly. No beats are issued.
- **FEED**
  - src_ready=1 and busy=1. dp_load = src_valid.
  - Each accepted beat increments the counter.
  - dp_first=dp_load when counter=0; dp_last=dp_load when counter=len-1.
  - The accepted dp_last beat moves the FSM to DRAIN.
  - Gaps in src_valid are legal. Each gap propagates as a bubble: out_valid=0 LATENCY cycles later.
- **DRAIN**
  - src_ready=0.
  - The FSM waits for out_last, then goes to DONE in the next cycle.
- **DONE**
  - done=1 and busy=1 for exactly one cycle, then return to IDLE.
- **Shadow pipeline**
  - It is LATENCY stages of {valid,last}, fed each cycle with {dp_load, dp_last}.
  - out_valid and out_last are taken from the final stage.
  - dp_first is not tracked.
- **start outside IDLE**
  - start is ignored in FEED, DRAIN and DONE.
  - A new job is accepted no earlier than the first IDLE cycle after done.
- **abort in FEED or DRAIN**
  - Next state is IDLE and the counter clears.
  - All shadow stages clear on the same edge, so out_valid=0 from the next cycle.
  - No done pulse is issued.
  - abort in the same cycle as an accepted beat: the beat counts as not loaded (dp_load is forced to 0 while abort=1).
- **abort in IDLE or DONE**: ignored. A DONE pulse completes normally.
- **Counter width**
  - The counter is LEN_WIDTH bits with no wrap, because len ≤ 2^LEN_WIDTH-1.
  - Comparisons use the latched len, not the live port.

## Timing
- **Reset**: rst_n low asynchronously forces state=IDLE, counter=0, latched len=0 and all shadow stages=0. All outputs are 0 during reset.
- **Outputs**: src_ready, busy and done are registered-state decodes. dp_load, dp_first and dp_last are combinational from src_valid, abort and state.
- **Start latency**: start sampled at edge s → FEED in cycle s+1, with src_ready=1 from cycle s+1.
- **Beat latency**: a beat accepted in cycle t gives out_valid=1 in cycle t+LATENCY.
- **Minimum job, len=1 with src_valid held high**:
  - beat at s+1;
  - out_valid/out_last at s+1+LATENCY;
  - done at s+2+LATENCY;
  - next start accepted at s+3+LATENCY.
- **Zero-length job, len=0**: start at s → done at s+1, IDLE at s+2. out_valid never asserts.
- **Output density**: the number of out_valid cycles equals the number of dp_load cycles per job, in the same order and with the same gaps.

## Test plan
- **Reset mid-job**: rst_n low during FEED → all outputs 0 immediately. After release, the FSM is in IDLE and a fresh len=2 job completes normally.
- **Back-to-back streaming**: LATENCY=8, start with len=4, src_valid held high → dp_load in cycles 1–4, dp_first in cycle 1, dp_last in cycle 4. out_valid in cycles 9–12, out_last in cycle 12, done in cycle 13, busy low in cycle 14.
- **Bubbles**: len=3 with src_valid pattern 1,0,0,1,1 → dp_load in cycles 1, 4 and 5; out_valid in cycles 9, 12 and 13; out_last in cycle 13; done in cycle 14.
- **Zero length**: start with len=0 → done=1 in cycle 1. No dp_load or out_valid at any time.
- **Abort during DRAIN**: len=2, abort in cycle 5 → out_valid stays 0 from cycle 6 onward, no done pulse, busy=0 in cycle 6. A new start in cycle 6 is accepted.
- **Start while busy**: start pulses in FEED and in the DONE cycle are both ignored. The len port changing mid-job does not alter the dp_last position.
